// File: rtl/beam_threshold_trigger.sv
// beam_threshold_trigger
//   Per-beam envelope threshold trigger for the beamforming stage output.
//   Each clock carries NSAMP signed samples for every beam. A four-stage
//   adder tree forms env = sum(|x|) per beam. The envelope is compared
//   against a double-buffered (shadow/active) threshold, and a holdoff FSM
//   turns the crossings into single-cycle triggers. Saturating per-beam
//   scalers integrate crossings over SCAL_PERIOD clocks so that software
//   can servo the thresholds.
//
// Ports
//   clk              processing clock (beam sample clock)
//   rst_i            synchronous reset, active-high
//   beam_i           beam b sample s at [(b*NSAMP+s)*BBITS +: BBITS]
//   trig_en_i        enables trigger generation
//   thresh_dat_i     threshold write data
//   thresh_adr_i     beam index for the threshold write
//   thresh_wr_i      writes shadow[thresh_adr_i]
//   thresh_update_i  copies all shadow thresholds to the active set
//   scal_adr_i       scaler readout beam index
//   scal_dat_o       latched scaler for scal_adr_i (1-cycle latency)
//   trig_o           single-cycle trigger pulse
//   trig_mask_o      beams over threshold on the trig_o cycle
module beam_threshold_trigger #(
  parameter int NBEAMS      = 10,
  parameter int NSAMP       = 8,
  parameter int BBITS       = 12,
  parameter int HOLDOFF     = 16,
  parameter int SCAL_PERIOD = 125000,
  parameter int SCBITS      = 16
) (
  input  logic                          clk,
  input  logic                          rst_i,
  input  logic [NBEAMS*NSAMP*BBITS-1:0] beam_i,
  input  logic                          trig_en_i,
  input  logic [14:0]                   thresh_dat_i,
  input  logic [3:0]                    thresh_adr_i,
  input  logic                          thresh_wr_i,
  input  logic                          thresh_update_i,
  input  logic [3:0]                    scal_adr_i,
  output logic [SCBITS-1:0]             scal_dat_o,
  output logic                          trig_o,
  output logic [NBEAMS-1:0]             trig_mask_o
);

  localparam int NPAIR  = NSAMP / 2;
  localparam int NQUAD  = NSAMP / 4;
  localparam int ENV_W  = BBITS + $clog2(NSAMP);
  localparam int CMP_W  = (ENV_W > 15) ? ENV_W : 15;
  localparam int PCNT_W = (SCAL_PERIOD > 1) ? $clog2(SCAL_PERIOD) : 1;
  localparam int HO_W   = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  typedef enum logic {IDLE, HOLD} state_t;

  // Magnitude of a two's complement sample; the most negative code maps to
  // 2^(BBITS-1), which still fits the unsigned BBITS-bit result.
  function automatic logic [BBITS-1:0] abs_mag(input logic signed [BBITS-1:0] x);
    logic [BBITS-1:0] m;
    m = x;
    return x[BBITS-1] ? (~m + 1'b1) : m;
  endfunction

  // Saturating scaler increment.
  function automatic logic [SCBITS-1:0] sat_inc(input logic [SCBITS-1:0] v,
                                                input logic inc);
    return (inc && (v != '1)) ? (v + 1'b1) : v;
  endfunction

  logic [BBITS-1:0]   abs_p1  [NBEAMS][NSAMP];
  logic [BBITS:0]     pair_p2 [NBEAMS][NPAIR];
  logic [BBITS+1:0]   quad_p3 [NBEAMS][NQUAD];
  logic [ENV_W-1:0]   env_p4  [NBEAMS];
  logic [ENV_W-1:0]   env_d   [NBEAMS];
  logic [NBEAMS-1:0]  over;

  logic [14:0]        shadow_q [NBEAMS];
  logic [14:0]        act_q    [NBEAMS];

  state_t             state_q;
  logic [HO_W-1:0]    hcnt_q;
  logic               trig_q;
  logic [NBEAMS-1:0]  mask_q;

  logic [PCNT_W-1:0]  pcnt_q;
  logic               wrap;
  logic [SCBITS-1:0]  live_q  [NBEAMS];
  logic [SCBITS-1:0]  latch_q [NBEAMS];
  logic [SCBITS-1:0]  scal_d;
  logic [SCBITS-1:0]  scal_q;

  // ---- S1..S3: magnitude, pair sums, quad sums ----
  always_ff @(posedge clk) begin
    if (rst_i) begin
      for (int b = 0; b < NBEAMS; b++) begin
        for (int s = 0; s < NSAMP; s++) abs_p1[b][s] <= '0;
        for (int p = 0; p < NPAIR; p++) pair_p2[b][p] <= '0;
        for (int q = 0; q < NQUAD; q++) quad_p3[b][q] <= '0;
      end
    end else begin
      for (int b = 0; b < NBEAMS; b++) begin
        for (int s = 0; s < NSAMP; s++)
          abs_p1[b][s] <= abs_mag(beam_i[(b*NSAMP+s)*BBITS +: BBITS]);
        for (int p = 0; p < NPAIR; p++)
          pair_p2[b][p] <= {1'b0, abs_p1[b][2*p]} + {1'b0, abs_p1[b][2*p+1]};
        for (int q = 0; q < NQUAD; q++)
          quad_p3[b][q] <= {1'b0, pair_p2[b][2*q]} + {1'b0, pair_p2[b][2*q+1]};
      end
    end
  end

  always_comb begin
    for (int b = 0; b < NBEAMS; b++) begin
      env_d[b] = '0;
      for (int q = 0; q < NQUAD; q++)
        env_d[b] = env_d[b] + ENV_W'(quad_p3[b][q]);
    end
  end

  // ---- S4: full envelope ----
  always_ff @(posedge clk) begin
    if (rst_i) begin
      for (int b = 0; b < NBEAMS; b++) env_p4[b] <= '0;
    end else begin
      for (int b = 0; b < NBEAMS; b++) env_p4[b] <= env_d[b];
    end
  end

  always_comb begin
    for (int b = 0; b < NBEAMS; b++)
      over[b] = CMP_W'(env_p4[b]) > CMP_W'(act_q[b]);
  end

  // Shadow/active thresholds. An update in the same cycle as a write copies
  // the old shadow contents, so the new value needs a later update.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      for (int b = 0; b < NBEAMS; b++) begin
        shadow_q[b] <= 15'h7FFF;
        act_q[b]    <= 15'h7FFF;
      end
    end else begin
      for (int b = 0; b < NBEAMS; b++) begin
        if (thresh_wr_i && (thresh_adr_i == 4'(b))) shadow_q[b] <= thresh_dat_i;
        if (thresh_update_i) act_q[b] <= shadow_q[b];
      end
    end
  end

  // ---- S5: trigger FSM with holdoff ----
  // HOLD is entered on the trigger cycle and lasts HOLDOFF cycles, so the
  // earliest retrigger is HOLDOFF+1 cycles after the previous pulse.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
      trig_q  <= 1'b0;
      mask_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (trig_en_i && (|over)) begin
            trig_q <= 1'b1;
            mask_q <= over;
            if (HOLDOFF > 0) begin
              state_q <= HOLD;
              hcnt_q  <= HO_W'(HOLDOFF);
            end
          end else begin
            trig_q <= 1'b0;
            mask_q <= '0;
          end
        end
        HOLD: begin
          trig_q <= 1'b0;
          mask_q <= '0;
          hcnt_q <= hcnt_q - 1'b1;
          if (hcnt_q <= HO_W'(1)) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          trig_q  <= 1'b0;
          mask_q  <= '0;
        end
      endcase
    end
  end

  assign trig_o      = trig_q;
  assign trig_mask_o = mask_q;

  // Scalers: the wrap cycle's own crossing is included in the latched value.
  assign wrap = (pcnt_q == PCNT_W'(SCAL_PERIOD - 1));

  always_ff @(posedge clk) begin
    if (rst_i) begin
      pcnt_q <= '0;
      for (int b = 0; b < NBEAMS; b++) begin
        live_q[b]  <= '0;
        latch_q[b] <= '0;
      end
    end else begin
      pcnt_q <= wrap ? '0 : (pcnt_q + 1'b1);
      for (int b = 0; b < NBEAMS; b++) begin
        if (wrap) begin
          latch_q[b] <= sat_inc(live_q[b], over[b]);
          live_q[b]  <= '0;
        end else begin
          live_q[b]  <= sat_inc(live_q[b], over[b]);
        end
      end
    end
  end

  always_comb begin
    scal_d = '0;
    for (int b = 0; b < NBEAMS; b++)
      if (scal_adr_i == 4'(b)) scal_d = latch_q[b];
  end

  always_ff @(posedge clk) begin
    if (rst_i) scal_q <= '0;
    else       scal_q <= scal_d;
  end

  assign scal_dat_o = scal_q;

endmodule

// File: tb/tb_beam_threshold_trigger.sv
module tb_beam_threshold_trigger;

  localparam int NB = 10;
  localparam int NS = 8;
  localparam int BB = 12;
  localparam int VW = NB * NS * BB;

  logic          clk = 1'b0;
  logic          rst_i;
  logic [VW-1:0] beam_i;
  logic          trig_en_i;
  logic [14:0]   thresh_dat_i;
  logic [3:0]    thresh_adr_i;
  logic          thresh_wr_i;
  logic          thresh_update_i;
  logic [3:0]    scal_adr_i;
  logic [15:0]   scal1;
  logic [3:0]    scal2;
  logic          trig1, trig2;
  logic [NB-1:0] mask1, mask2;

  beam_threshold_trigger #(.NBEAMS(NB), .NSAMP(NS), .BBITS(BB), .HOLDOFF(16),
                           .SCAL_PERIOD(100), .SCBITS(16)) dut (
    .clk(clk), .rst_i(rst_i), .beam_i(beam_i), .trig_en_i(trig_en_i),
    .thresh_dat_i(thresh_dat_i), .thresh_adr_i(thresh_adr_i),
    .thresh_wr_i(thresh_wr_i), .thresh_update_i(thresh_update_i),
    .scal_adr_i(scal_adr_i), .scal_dat_o(scal1), .trig_o(trig1),
    .trig_mask_o(mask1));

  // Narrow-scaler instance sharing all stimulus, used for saturation.
  beam_threshold_trigger #(.NBEAMS(NB), .NSAMP(NS), .BBITS(BB), .HOLDOFF(16),
                           .SCAL_PERIOD(100), .SCBITS(4)) dut_sat (
    .clk(clk), .rst_i(rst_i), .beam_i(beam_i), .trig_en_i(trig_en_i),
    .thresh_dat_i(thresh_dat_i), .thresh_adr_i(thresh_adr_i),
    .thresh_wr_i(thresh_wr_i), .thresh_update_i(thresh_update_i),
    .scal_adr_i(scal_adr_i), .scal_dat_o(scal2), .trig_o(trig2),
    .trig_mask_o(mask2));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; logic [NB-1:0] mask; } trig_exp_t;
  typedef struct { int cyc; int sel; logic [15:0] val; } scal_exp_t;

  trig_exp_t tq[$];
  scal_exp_t sq[$];
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
  endtask

  // Monitor: pops expected triggers / scaler reads as the DUT presents them.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      while (tq.size() > 0 && tq[0].cyc < cyc) begin
        chk("missed_trig_cycle", 32'(tq[0].cyc), 32'hFFFF_FFFF);
        void'(tq.pop_front());
      end
      if (trig1 === 1'b1) begin
        if (tq.size() == 0) begin
          chk("unexpected_trig", 32'(trig1), 32'd0);
        end else begin
          trig_exp_t e;
          e = tq.pop_front();
          chk("trig_cycle", 32'(cyc), 32'(e.cyc));
          chk("trig_mask", 32'(mask1), 32'(e.mask));
        end
      end else begin
        chk("idle_trig", 32'(trig1), 32'd0);
        chk("idle_mask", 32'(mask1), 32'd0);
      end
      while (sq.size() > 0 && sq[0].cyc <= cyc) begin
        scal_exp_t s;
        s = sq.pop_front();
        if (s.cyc < cyc) chk("scal_stale", 32'(s.cyc), 32'(cyc));
        else if (s.sel == 0) chk("scal16", 32'(scal1), 32'(s.val));
        else chk("scal4", 32'(scal2), 32'(s.val));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int target);
    if (target > cyc) tick(target - cyc);
  endtask

  task automatic set_beam(input int b, input int v);
    logic [BB-1:0] t;
    t = v[BB-1:0];
    for (int s = 0; s < NS; s++) beam_i[(b*NS+s)*BB +: BB] = t;
  endtask

  task automatic exp_trig(input int offs, input logic [NB-1:0] m);
    trig_exp_t e;
    e.cyc = cyc + offs;
    e.mask = m;
    tq.push_back(e);
  endtask

  task automatic set_thr(input int a, input int v, input logic upd);
    thresh_adr_i = 4'(a);
    thresh_dat_i = 15'(v);
    thresh_wr_i = 1'b1;
    thresh_update_i = upd;
    tick(1);
    thresh_wr_i = 1'b0;
    thresh_update_i = 1'b0;
  endtask

  task automatic update();
    thresh_update_i = 1'b1;
    tick(1);
    thresh_update_i = 1'b0;
  endtask

  task automatic rd(input int a, input int e16, input int e4);
    scal_exp_t s;
    scal_adr_i = 4'(a);
    s.cyc = cyc + 1;
    s.sel = 0; s.val = 16'(e16); sq.push_back(s);
    s.sel = 1; s.val = 16'(e4);  sq.push_back(s);
    tick(1);
  endtask

  // One-cycle pulse on beam b with every sample at v; expected mask m (0 = none).
  task automatic pulse(input int b, input int v, input logic [NB-1:0] m);
    set_beam(b, v);
    if (m != '0) exp_trig(5, m);
    tick(1);
    beam_i = '0;
    tick(25);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick(2);
    rst_i = 1'b0;
  endtask

  initial begin
    int r;
    rst_i = 1'b1;
    beam_i = '0;
    trig_en_i = 1'b1;
    thresh_dat_i = '0;
    thresh_adr_i = '0;
    thresh_wr_i = 1'b0;
    thresh_update_i = 1'b0;
    scal_adr_i = '0;
    tick(1);
    rd(0, 0, 0);
    tick(2);
    rst_i = 1'b0;

    // Reset thresholds: random full-scale beams never cross.
    for (int i = 0; i < 1000; i++) begin
      for (int w = 0; w < VW/32; w++) beam_i[w*32 +: 32] = $urandom;
      tick(1);
    end
    beam_i = '0;
    tick(8);
    for (int a = 0; a < NB; a++) rd(a, 0, 0);
    rd(10, 0, 0);
    rd(15, 0, 0);

    // Beam 3 at 1000: env 1008 crosses, env 1000 does not (strict compare).
    set_thr(3, 1000, 1'b0);
    update();
    tick(2);
    pulse(3, 126, 10'h008);
    pulse(3, 125, 10'h000);

    // Negative full scale on beam 0 (env 16384).
    set_thr(0, 16383, 1'b0);
    update();
    tick(2);
    pulse(0, -2048, 10'h001);
    set_beam(3, 126);
    pulse(0, -2048, 10'h009);
    set_thr(0, 16384, 1'b0);
    update();
    tick(2);
    pulse(0, -2048, 10'h000);

    // Holdoff: continuous crossing on beam 3 for 40 cycles.
    exp_trig(5, 10'h008);
    exp_trig(22, 10'h008);
    exp_trig(39, 10'h008);
    set_beam(3, 126);
    tick(40);
    beam_i = '0;
    tick(30);

    // Shadow/update ordering on beam 7 (env 504 vs threshold 500).
    set_thr(7, 500, 1'b0);
    tick(2);
    pulse(7, 63, 10'h000);
    set_thr(7, 15'h7FFF, 1'b0);
    set_thr(7, 500, 1'b1);
    tick(2);
    pulse(7, 63, 10'h000);
    update();
    tick(2);
    pulse(7, 63, 10'h080);

    // Scalers with triggering disabled; period aligned to reset release.
    trig_en_i = 1'b0;
    do_reset();
    r = cyc;
    set_thr(5, 100, 1'b0);
    update();
    set_beam(5, 13);
    tick(37);
    beam_i = '0;
    wait_until(r + 50);
    rd(5, 0, 0);
    wait_until(r + 105);
    rd(5, 37, 15);
    rd(4, 0, 0);
    rd(12, 0, 0);

    // Reset in the middle of the next period clears live and latched counts.
    wait_until(r + 110);
    set_beam(5, 13);
    tick(10);
    beam_i = '0;
    tick(5);
    do_reset();
    r = cyc;
    rd(5, 0, 0);
    wait_until(r + 105);
    rd(5, 0, 0);

    tick(10);
    chk("trig_queue_drained", 32'(tq.size()), 32'd0);
    chk("scal_queue_drained", 32'(sq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
